// File: rtl/bitstream_pkg.sv
// Shared types and constants for the stochastic bitstream network.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DECODE_WIDTH = 8;

  // A zero-length warm-up still needs a 1-bit counter to keep ports legal.
  function automatic int warm_width(input int warmup);
    return (warmup < 1) ? 1 : $clog2(warmup + 1);
  endfunction

endpackage

// File: rtl/bitstream_decoder_if.sv
// Handshake bundle between the bitstream decoder and its host or next layer.
interface bitstream_decoder_if import bitstream_pkg::*; #(
  parameter int WIDTH = DECODE_WIDTH
);
  logic           x;
  logic           start;
  logic           abort;
  logic           ready;
  logic           busy;
  logic           valid;
  logic [WIDTH:0] value;

  modport master (output x, start, abort, ready, input busy, valid, value);
  modport slave  (input x, start, abort, ready, output busy, valid, value);
endinterface

// File: rtl/window_counter.sv
// WIDTH+1-bit sample counter with clear/enable and a terminal flag at 2**WIDTH-1.
module window_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] CNT_LAST = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0] count_q;
  logic [WIDTH:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_LAST);
endmodule

// File: rtl/bitstream_decoder.sv
// Counts ones on a unipolar bitstream over a 2**WIDTH window after a warm-up
// period and hands the count out over a valid/ready handshake.
module bitstream_decoder import bitstream_pkg::*; #(
  parameter int WIDTH  = DECODE_WIDTH,
  parameter int WARMUP = 16
) (
  input logic                clk,
  input logic                n_rst,
  bitstream_decoder_if.slave bus
);
  localparam int                WARM_W    = warm_width(WARMUP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

  state_e            state_q;
  state_e            state_d;
  logic [WARM_W-1:0] warm_q;
  logic [WARM_W-1:0] warm_d;
  logic [WIDTH:0]    ones_q;
  logic [WIDTH:0]    ones_d;
  logic [WIDTH:0]    value_q;
  logic [WIDTH:0]    value_d;
  logic [WIDTH:0]    x_ext_s;
  logic              win_clr_s;
  logic              win_en_s;
  logic              win_tc_s;

  assign x_ext_s = {{WIDTH{1'b0}}, bus.x};

  window_counter #(.WIDTH(WIDTH)) u_window (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (win_clr_s),
    .en_i  (win_en_s),
    .tc_o  (win_tc_s)
  );

  // Abort overrides every state; value is only ever written on the final sample.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    ones_d    = ones_q;
    value_d   = value_q;
    win_clr_s = 1'b0;
    win_en_s  = 1'b0;
    if (bus.abort) begin
      state_d   = IDLE;
      warm_d    = '0;
      ones_d    = '0;
      win_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d   = (WARMUP == 0) ? COUNT : WARM;
            warm_d    = '0;
            ones_d    = '0;
            win_clr_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        WARM: begin
          if (warm_q == WARM_LAST) begin
            state_d = COUNT;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + WARM_ONE;
          end
        end
        COUNT: begin
          win_en_s = 1'b1;
          ones_d   = ones_q + x_ext_s;
          if (win_tc_s) begin
            state_d = DONE;
            value_d = ones_q + x_ext_s;
          end else begin
            state_d = COUNT;
          end
        end
        DONE: begin
          if (bus.ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      warm_q  <= '0;
      ones_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      ones_q  <= ones_d;
      value_q <= value_d;
    end
  end

  assign bus.busy  = (state_q == WARM) || (state_q == COUNT);
  assign bus.valid = (state_q == DONE);
  assign bus.value = value_q;
endmodule
